// File: rtl/neuron_pkg.sv
// Shared constants for the neuron datapath: activation mode encodings,
// leaky-ReLU slope shift, accumulator headroom and a clog2 helper.
// No ports; imported by neuron_vec_pipe and neuron_act_quant.
package neuron_pkg;

    // Activation select, sampled with the last beat of a frame
    localparam logic [1:0] ACT_ID    = 2'd0;
    localparam logic [1:0] ACT_RELU  = 2'd1;
    localparam logic [1:0] ACT_LEAKY = 2'd2;
    localparam logic [1:0] ACT_RSVD  = 2'd3;   // behaves as identity

    // Leaky slope is 1/8, applied as an arithmetic shift (floors)
    localparam int LEAKY_SHIFT = 3;

    // Default accumulator is 2*N + ACC_HEADROOM bits
    localparam int ACC_HEADROOM = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_act_quant.sv
// Activation + quantiser: arithmetic shift, identity/ReLU/leaky, clamp to N bits.
// Latency: combinational (0 cycles).
// Backpressure: none; caller registers the result.
// Ports: r (ACC_W signed pre-activation), mode (activation select),
//        q (N-bit signed result), sat (clamp changed the value).
module neuron_act_quant
    import neuron_pkg::*;
#(
    parameter int N     = 18,
    parameter int ACC_W = 2 * N + ACC_HEADROOM,
    parameter int SHIFT = N
) (
    input  logic signed [ACC_W-1:0] r,
    input  logic        [1:0]       mode,
    output logic        [N-1:0]     q,
    output logic                    sat
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

    logic signed [ACC_W-1:0] y;
    logic signed [ACC_W-1:0] a;

    always_comb begin
        y   = r >>> SHIFT;
        a   = y;
        q   = '0;
        sat = 1'b0;
        case (mode)
            ACT_RELU:  if (y[ACC_W-1]) a = '0;
            ACT_LEAKY: if (y[ACC_W-1]) a = y >>> LEAKY_SHIFT;
            ACT_ID,
            ACT_RSVD:  a = y;
        endcase
        // Clamp in full width so sat reflects any out-of-range value
        if (a > MAX_V) begin
            q   = MAX_V[N-1:0];
            sat = 1'b1;
        end else if (a < MIN_V) begin
            q   = MIN_V[N-1:0];
            sat = 1'b1;
        end else begin
            q   = a[N-1:0];
        end
    end

endmodule

// File: rtl/neuron_vec_pipe.sv
// K-lane MAC neuron: products -> adder tree -> frame accumulator + bias -> act/quant.
// Latency: last beat accepted in cycle t gives out_valid in cycle t+3; 1 beat/cycle.
// Backpressure: out_valid & ~out_ready freezes every stage and drops in_ready.
// Ports: clk/rst (sync, active high); in_valid/in_ready/in_w/in_x/in_last/in_bias/in_mode
//        input beat stream; out_valid/out_ready/out_data/out_sat result stream.
module neuron_vec_pipe
    import neuron_pkg::*;
#(
    parameter int N     = 18,
    parameter int K     = 4,
    parameter int ACC_W = 2 * N + ACC_HEADROOM,
    parameter int SHIFT = N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K*N-1:0]   in_w,
    input  logic [K*N-1:0]   in_x,
    input  logic             in_last,
    input  logic [2*N-1:0]   in_bias,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_sat
);

    localparam int PW     = 2 * N;
    localparam int TREE_W = PW + clog2(K);

    logic en;
    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en;

    // ---------------- S1: lane products ----------------
    logic signed [PW-1:0] prod_c  [K];
    logic signed [PW-1:0] s1_prod [K];
    logic                 s1_vld, s1_last;
    logic signed [PW-1:0] s1_bias;
    logic [1:0]           s1_mode;

    for (genvar i = 0; i < K; i++) begin : g_lane
        assign prod_c[i] = PW'($signed(in_w[i*N +: N])) * PW'($signed(in_x[i*N +: N]));
    end

    always_ff @(posedge clk) begin
        if (rst)     s1_vld <= 1'b0;
        else if (en) s1_vld <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < K; i++) s1_prod[i] <= prod_c[i];
            s1_last <= in_last;
            s1_bias <= in_bias;
            s1_mode <= in_mode;
        end
    end

    // ---------------- S2: adder tree ----------------
    logic signed [TREE_W-1:0] tree_sum;
    logic signed [ACC_W-1:0]  s2_sum;
    logic                     s2_vld, s2_last;
    logic signed [PW-1:0]     s2_bias;
    logic [1:0]               s2_mode;

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < K; i++) tree_sum = tree_sum + TREE_W'(s1_prod[i]);
    end

    always_ff @(posedge clk) begin
        if (rst)     s2_vld <= 1'b0;
        else if (en) s2_vld <= s1_vld;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s2_sum  <= ACC_W'(tree_sum);
            s2_last <= s1_last;
            s2_bias <= s1_bias;
            s2_mode <= s1_mode;
        end
    end

    // ---------------- S3: accumulate, bias, activate ----------------
    logic signed [ACC_W-1:0] acc, acc_n, res;
    logic                    frame_start;
    logic [N-1:0]            q;
    logic                    q_sat;
    logic                    load;

    // frame_start stands in for a zeroed acc so a new frame never sees stale sums
    assign acc_n = (frame_start ? '0 : acc) + s2_sum;
    assign res   = acc_n + ACC_W'(s2_bias);
    assign load  = en & s2_vld & s2_last;

    neuron_act_quant #(
        .N     (N),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_act_quant (
        .r    (res),
        .mode (s2_mode),
        .q    (q),
        .sat  (q_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            frame_start <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sat     <= 1'b0;
        end else begin
            if (en && s2_vld) begin
                if (s2_last) begin
                    acc         <= '0;
                    frame_start <= 1'b1;
                end else begin
                    acc         <= acc_n;
                    frame_start <= 1'b0;
                end
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= q;
                out_sat   <= q_sat;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neuron_vec_pipe.sv
// Scoreboard bench: two DUTs (SHIFT=0 and SHIFT=N) share one input stream;
// a frame-level arithmetic model pushes expected results, a monitor pops them.
module tb_neuron_vec_pipe;

    localparam int N = 18;
    localparam int K = 4;
    localparam longint MAXV = 131071;
    localparam longint MINV = -131072;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_last, out_ready;
    logic [K*N-1:0]   in_w, in_x;
    logic [2*N-1:0]   in_bias;
    logic [1:0]       in_mode;
    logic             in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_sat_a, out_sat_b;
    logic [N-1:0]     out_data_a, out_data_b;

    always #5 clk = ~clk;

    neuron_vec_pipe #(.N(N), .K(K), .SHIFT(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_w(in_w), .in_x(in_x), .in_last(in_last), .in_bias(in_bias), .in_mode(in_mode),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_sat(out_sat_a)
    );

    neuron_vec_pipe #(.N(N), .K(K)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_w(in_w), .in_x(in_x), .in_last(in_last), .in_bias(in_bias), .in_mode(in_mode),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_sat(out_sat_b)
    );

    typedef struct {
        logic [N-1:0] da;
        logic         sa;
        logic [N-1:0] db;
        logic         sb;
    } exp_t;

    exp_t   sbq[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    longint frame_sum = 0;
    bit     rdy_rand = 0;
    bit     rdy_low  = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // floor(a / 2^s) by integer division, not by shifting
    function automatic longint floor_div(input longint a, input int s);
        longint p, qv;
        p  = 64'sd1 <<< s;
        qv = a / p;
        if ((a % p) != 0 && a < 0) qv = qv - 1;
        return qv;
    endfunction

    function automatic void ref_quant(input longint r, input int sh, input logic [1:0] mode,
                                      output logic [N-1:0] d, output logic s);
        longint m, w, y, z;
        m = 64'sd1 <<< 44;               // accumulator wraps modulo 2^44
        w = r % m;
        if (w >= m / 2)  w = w - m;
        if (w < -(m / 2)) w = w + m;
        y = floor_div(w, sh);
        if (mode == 2'd1 && y < 0) y = 0;
        if (mode == 2'd2 && y < 0) y = floor_div(y, 3);
        z = y;
        if (z > MAXV) z = MAXV;
        if (z < MINV) z = MINV;
        s = (z != y);
        d = z[N-1:0];
    endfunction

    function automatic logic [K*N-1:0] lanes(input int a0, input int a1, input int a2, input int a3);
        int v[4];
        logic [K*N-1:0] r;
        v = '{a0, a1, a2, a3};
        r = '0;
        for (int i = 0; i < K; i++) r[i*N +: N] = v[i][N-1:0];
        return r;
    endfunction

    function automatic logic [K*N-1:0] rand_lanes();
        logic [K*N-1:0] r;
        for (int i = 0; i < K; i++) r[i*N +: N] = N'($urandom);
        return r;
    endfunction

    task automatic send_beat(input logic [K*N-1:0] w, input logic [K*N-1:0] x, input bit last,
                             input logic [2*N-1:0] bias, input logic [1:0] mode);
        int   tries;
        exp_t e;
        longint fs;
        @(negedge clk);
        in_w = w; in_x = x; in_last = last; in_bias = bias; in_mode = mode; in_valid = 1'b1;
        #1;
        tries = 0;
        while (!in_ready_a && tries < 200) begin
            @(negedge clk); #1;
            tries++;
        end
        if (!in_ready_a) begin
            check(1'b0, "in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        for (int i = 0; i < K; i++)
            frame_sum += longint'($signed(w[i*N +: N])) * longint'($signed(x[i*N +: N]));
        if (last) begin
            fs = frame_sum + longint'($signed(bias));
            ref_quant(fs, 0, mode, e.da, e.sa);
            ref_quant(fs, N, mode, e.db, e.sb);
            sbq.push_back(e);
            frame_sum = 0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic bubble(input int n);
        repeat (n) @(posedge clk);
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy_low)       out_ready = 1'b0;
            else if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
            else               out_ready = 1'b1;
        end
    end

    // Monitor: compares popped expectations, handshake and hold rules
    initial begin
        bit           held;
        logic [N-1:0] hd;
        logic         hs;
        exp_t         e;
        held = 1'b0; hd = '0; hs = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                held = 1'b0;
                continue;
            end
            check(in_ready_a == !(out_valid_a && !out_ready), "in_ready_vs_stall",
                  longint'(in_ready_a), longint'(!(out_valid_a && !out_ready)));
            if (held)
                check(out_valid_a && out_data_a == hd && out_sat_a == hs, "hold_stable",
                      $signed(out_data_a), $signed(hd));
            if (out_valid_a && out_ready) begin
                if (sbq.size() == 0) begin
                    check(1'b0, "unexpected_output", $signed(out_data_a), 0);
                end else begin
                    e = sbq.pop_front();
                    check(out_data_a == e.da, "data_shift0", $signed(out_data_a), $signed(e.da));
                    check(out_sat_a == e.sa, "sat_shift0", longint'(out_sat_a), longint'(e.sa));
                    check(out_valid_b, "valid_shiftN", longint'(out_valid_b), 1);
                    check(out_data_b == e.db, "data_shiftN", $signed(out_data_b), $signed(e.db));
                    check(out_sat_b == e.sb, "sat_shiftN", longint'(out_sat_b), longint'(e.sb));
                end
            end
            held = out_valid_a && !out_ready;
            hd   = out_data_a;
            hs   = out_sat_a;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int len;
        logic [63:0] rb;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        in_w = '0; in_x = '0; in_bias = '0; in_mode = '0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(!out_valid_a && !out_valid_b, "reset_out_valid", longint'(out_valid_a), 0);
        check(out_data_a == 0 && out_data_b == 0, "reset_out_data", longint'(out_data_a), 0);
        check(!out_sat_a, "reset_out_sat", longint'(out_sat_a), 0);
        rst = 1'b0;
        #1;
        check(in_ready_a == 1'b1, "in_ready_after_reset", longint'(in_ready_a), 1);

        // ---- reset mid-frame: pending result and partial sum both discarded ----
        send_beat(lanes(9, 9, 9, 9), lanes(9, 9, 9, 9), 1'b1, 36'd0, 2'd0);
        send_beat(lanes(100, 200, 300, 400), lanes(7, 7, 7, 7), 1'b0, 36'd5, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check(!out_valid_a && !out_valid_b, "midreset_out_valid", longint'(out_valid_a), 0);
        check(out_data_a == 0, "midreset_out_data", longint'(out_data_a), 0);
        sbq.delete();
        frame_sum = 0;
        rst = 1'b0;

        // ---- single-beat frame, latency ----
        send_beat(lanes(1, 2, 3, 4), lanes(5, 6, 7, 8), 1'b1, 36'd0, 2'd0);
        lat = 1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (out_valid_a) begin
                lat = c + 1;
                break;
            end
            lat = c + 2;
        end
        check(lat == 3, "latency_cycles", lat, 3);
        bubble(3);

        // ---- three-beat frames of -1*1 under each activation ----
        for (int m = 0; m < 3; m++) begin
            logic [1:0] md;
            md = (m == 0) ? 2'd1 : (m == 1) ? 2'd2 : 2'd0;
            send_beat(lanes(-1, -1, -1, -1), lanes(1, 1, 1, 1), 1'b0, 36'd77, 2'd3);
            send_beat(lanes(-1, -1, -1, -1), lanes(1, 1, 1, 1), 1'b0, 36'd99, 2'd1);
            send_beat(lanes(-1, -1, -1, -1), lanes(1, 1, 1, 1), 1'b1, 36'd0, md);
        end

        // ---- saturation both directions ----
        send_beat(lanes(131071, 131071, 131071, 131071), lanes(131071, 131071, 131071, 131071),
                  1'b1, 36'd0, 2'd0);
        send_beat(lanes(-131071, -131071, -131071, -131071), lanes(131071, 131071, 131071, 131071),
                  1'b1, 36'd0, 2'd0);

        // ---- backpressure: 10-cycle stall under back-to-back single-beat frames ----
        fork
            begin
                for (int f = 0; f < 8; f++)
                    send_beat(rand_lanes(), rand_lanes(), 1'b1, 36'(f * 1000), 2'(f));
            end
            begin
                repeat (2) @(negedge clk);
                rdy_low = 1'b1;
                repeat (10) @(negedge clk);
                rdy_low = 1'b0;
            end
        join

        // ---- bias/mode only from last beat: 1-beat frame, bubble, 2-beat frame ----
        send_beat(rand_lanes(), rand_lanes(), 1'b1, 36'd12345, 2'd1);
        bubble(2);
        send_beat(rand_lanes(), rand_lanes(), 1'b0, 36'h7_0000_0000, 2'd1);
        send_beat(rand_lanes(), rand_lanes(), 1'b1, 36'hF_FFF0_0000, 2'd2);

        // ---- randomized frames with random bubbles and random out_ready ----
        rdy_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                rb = {$urandom, $urandom};
                send_beat(rand_lanes(), rand_lanes(), (b == len - 1), rb[35:0], 2'($urandom));
                if ($urandom_range(0, 3) == 0) bubble($urandom_range(1, 3));
            end
        end
        rdy_rand = 1'b0;

        // ---- drain ----
        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        check(sbq.size() == 0, "results_outstanding", sbq.size(), 0);
        @(negedge clk);
        check(!out_valid_a, "idle_out_valid", longint'(out_valid_a), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
